// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blank flags are built only when BCD_LZB_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    sr_q, sr_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
  logic [ACC_W:0]      acc_shift;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                accept, last_bit, ovf_next;

  assign accept   = start && (state_q != S_CONV);
  assign last_bit = (state_q == S_CONV) && (cnt_q == CNT_W'(1));

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? acc_q[4*gi +: 4] + 4'd3
                                                              : acc_q[4*gi +: 4];
    end
  endgenerate

  // Extra leading bit can never be set for legal BIN_W, but folding it into ovf keeps it observable.
  assign acc_shift = {acc_adj, sr_q[BIN_W-1]};
  assign ovf_next  = |acc_shift[ACC_W -: 5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = start ? S_CONV : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Results are committed on the final shift so they are already valid during the done cycle.
  always_comb begin
    sr_d  = sr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if (accept) begin
      sr_d  = bin;
      acc_d = '0;
      cnt_d = CNT_W'(BIN_W);
    end else if (state_q == S_CONV) begin
      sr_d  = sr_q << 1;
      acc_d = acc_shift[ACC_W-1:0];
      cnt_d = cnt_q - CNT_W'(1);
      if (last_bit) begin
        ovf_d = ovf_next;
        bcd_d = ovf_next ? {(4*DIGITS){1'b1}} : acc_shift[4*DIGITS-1:0];
      end
    end
  end

  always_comb begin
    busy = (state_q == S_CONV);
    done = (state_q == S_DONE);
    bcd  = bcd_q;
    ovf  = ovf_q;
  end

`ifdef BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d, hi_zero;
  logic              zero_run;

  always_comb begin
    hi_zero  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (acc_shift[4*i +: 4] == 4'd0);
      hi_zero[i] = zero_run;
    end
    blank_d = blank_q;
    if (last_bit) blank_d = ovf_next ? '0 : {hi_zero[DIGITS-1:1], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blank_q <= '0;
    else     blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, overflow, ignored starts, reset abort, back-to-back.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [BIN_W-1:0]    bin = '0;
  logic                busy, done, ovf;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;

  int n_assert = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIGITS-1:0] lzb(input logic [DIGITS-1:0] b);
`ifdef BCD_LZB_EN
    return b;
`else
    return '0;
`endif
  endfunction

  // Pulse start for one cycle, wait for done and check timing plus result.
  task automatic do_conv(input string tag, input logic [BIN_W-1:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf,
                         input logic [DIGITS-1:0] exp_blank);
    int n, nbusy;
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = BIN_W'($urandom);
    n     = 1;
    nbusy = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) nbusy++;
    end
    chk({tag, "_lat"}, n, BIN_W + 1);
    chk({tag, "_busy"}, nbusy, BIN_W);
    chk({tag, "_bcd"}, bcd, exp_bcd);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_blank"}, blank, lzb(exp_blank));
    tick();
    chk({tag, "_pulse"}, done, 0);
    $display("conv %s bin=%0d bcd=%h ovf=%b blank=%b", tag, v, bcd, ovf, blank);
  endtask

  initial begin
    int n, ndone;
    logic [BIN_W-1:0] vals [3];
    logic [15:0]      exps [3];
    logic [3:0]       blks [3];

    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_blank", blank, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    do_conv("t1_1234", 14'd1234, 16'h1234, 1'b0, 4'b0000);
    do_conv("t2_9999", 14'd9999, 16'h9999, 1'b0, 4'b0000);
    do_conv("t2_10000", 14'd10000, 16'hFFFF, 1'b1, 4'b0000);
    do_conv("t3_16383", 14'd16383, 16'hFFFF, 1'b1, 4'b0000);
    do_conv("t3_zero", 14'd0, 16'h0000, 1'b0, 4'b1110);

    // A start raised while busy must be dropped, not queued.
    start = 1'b1;
    bin   = 14'd7;
    tick();
    start = 1'b0;
    n = 1;
    ndone = 0;
    for (int c = 2; c <= 60; c++) begin
      if (c == 6) begin
        start = 1'b1;
        bin   = 14'd55;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("t4_lat", c, BIN_W + 1);
          chk("t4_bcd", bcd, 16'h0007);
          chk("t4_blank", blank, lzb(4'b1110));
        end
      end
    end
    chk("t4_ndone", ndone, 1);
    chk("t4_hold", bcd, 16'h0007);
    $display("conv t4_ignore bcd=%h dones=%0d", bcd, ndone);

    // Asynchronous reset in the middle of a conversion.
    start = 1'b1;
    bin   = 14'd1234;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_bcd", bcd, 0);
    chk("t5_ovf", ovf, 0);
    chk("t5_blank", blank, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    $display("conv t5_abort bcd=%h busy=%b", bcd, busy);
    do_conv("t5_42", 14'd42, 16'h0042, 1'b0, 4'b1100);

    // start held high: each DONE cycle immediately accepts the next value.
    vals[0] = 14'd100;  exps[0] = 16'h0100; blks[0] = 4'b1000;
    vals[1] = 14'd2047; exps[1] = 16'h2047; blks[1] = 4'b0000;
    vals[2] = 14'd9000; exps[2] = 16'h9000; blks[2] = 4'b0000;
    start = 1'b1;
    bin   = vals[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      n = 1;
      if (k < 2) bin = vals[k+1];
      else begin
        bin   = '0;
        start = 1'b0;
      end
      while (!done && n < 40) begin
        tick();
        n++;
      end
      chk("t6_period", n, BIN_W + 1);
      chk("t6_bcd", bcd, exps[k]);
      chk("t6_blank", blank, lzb(blks[k]));
      $display("conv t6_b2b k=%0d bcd=%h cycles=%0d", k, bcd, n);
    end
    tick();
    chk("t6_idle", done, 0);
    do_conv("t6_305", 14'd305, 16'h0305, 1'b0, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
